rgmii_tx_framer: RTL and testbench

Gigabit Ethernet transmit framer in the `clk125` domain. It turns a byte stream from the packet builder into complete MAC frames: preamble, SFD, payload, zero padding, CRC-32 FCS and inter-frame gap. Its outputs drive the 8-bit data / 2-bit control inputs of the RGMII TX output multiplexer. The low nibble and `tx_ctl[0]` go out on the rising edge; the high nibble and `tx_ctl[1]` go out on the falling edge.

---
 rtl/rgmii_tx_framer.sv | 227 ++++++++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_framer.sv
// Gigabit Ethernet transmit framer (125 MHz byte clock).
// Wraps a payload byte stream into a full MAC frame: 7x preamble, SFD,
// payload, zero padding up to MIN_FRAME, CRC-32 FCS, then IFG idle bytes.
// tx_data / tx_ctl are registered and feed the RGMII DDR output mux.
// tx_ctl encoding: 00 idle, 11 frame byte, 01 error byte (TX_ER asserted).
module rgmii_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic [1:0]  tx_ctl,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic [15:0] underruns
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        DISCARD,
        GAP
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [16:0] MIN_FRAME_L = 17'(MIN_FRAME);
    localparam logic [7:0]  GAP_LAST    = 8'(IFG - 1);

    localparam logic [1:0]  CTL_IDLE = 2'b00;
    localparam logic [1:0]  CTL_DATA = 2'b11;
    localparam logic [1:0]  CTL_ERR  = 2'b01;

    state_t      state_reg, state_next;
    logic [15:0] byte_cnt_reg, byte_cnt_next;   // payload + pad bytes sent
    logic [7:0]  sub_cnt_reg, sub_cnt_next;     // preamble / FCS / gap index
    logic [31:0] crc_reg, crc_next;
    logic        aborted_reg, aborted_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic [1:0]  tx_ctl_reg, tx_ctl_next;
    logic [15:0] frames_sent_reg, frames_sent_next;
    logic [15:0] underruns_reg, underruns_next;

    // Byte-wide CRC update, unrolled one bit per stage so the register
    // absorbs a full byte each clock. During PAD the fed byte is zero.
    logic [7:0]       crc_byte;
    logic [8:0][31:0] crc_stage;
    logic [31:0]      crc_upd;

    assign crc_byte     = (state_reg == PAD) ? 8'h00 : s_data;
    assign crc_stage[0] = crc_reg ^ {24'h000000, crc_byte};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
            assign crc_stage[gi + 1] = crc_stage[gi][0]
                                     ? ((crc_stage[gi] >> 1) ^ CRC_POLY)
                                     : (crc_stage[gi] >> 1);
        end
    endgenerate

    assign crc_upd = crc_stage[8];

    // Saturating increment and "one more byte" value for the length tests.
    logic [15:0] byte_cnt_inc;
    logic [16:0] byte_cnt_plus1;

    assign byte_cnt_inc   = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;
    assign byte_cnt_plus1 = {1'b0, byte_cnt_reg} + 17'd1;

    // Ready depends on the state register only, never on s_valid.
    assign s_ready     = (state_reg == PAYLOAD) || (state_reg == DISCARD);
    assign busy        = (state_reg != IDLE);
    assign tx_data     = tx_data_reg;
    assign tx_ctl      = tx_ctl_reg;
    assign frames_sent = frames_sent_reg;
    assign underruns   = underruns_reg;

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= 16'd0;
            sub_cnt_reg     <= 8'd0;
            crc_reg         <= CRC_INIT;
            aborted_reg     <= 1'b0;
            tx_data_reg     <= 8'h00;
            tx_ctl_reg      <= CTL_IDLE;
            frames_sent_reg <= 16'd0;
            underruns_reg   <= 16'd0;
        end else begin
            state_reg       <= state_next;
            byte_cnt_reg    <= byte_cnt_next;
            sub_cnt_reg     <= sub_cnt_next;
            crc_reg         <= crc_next;
            aborted_reg     <= aborted_next;
            tx_data_reg     <= tx_data_next;
            tx_ctl_reg      <= tx_ctl_next;
            frames_sent_reg <= frames_sent_next;
            underruns_reg   <= underruns_next;
        end
    end

    // Next-state and next-output decode; the byte registered at each edge
    // is the one chosen by the state that was current before that edge.
    always_comb begin
        state_next       = state_reg;
        byte_cnt_next    = byte_cnt_reg;
        sub_cnt_next     = sub_cnt_reg;
        crc_next         = crc_reg;
        aborted_next     = aborted_reg;
        tx_data_next     = 8'h00;
        tx_ctl_next      = CTL_IDLE;
        frames_sent_next = frames_sent_reg;
        underruns_next   = underruns_reg;

        case (state_reg)
            IDLE: begin
                // The start edge already emits preamble byte 1; the
                // triggering payload byte stays on the bus.
                if (s_valid) begin
                    tx_data_next  = 8'h55;
                    tx_ctl_next   = CTL_DATA;
                    state_next    = PREAMBLE;
                    sub_cnt_next  = 8'd1;
                    byte_cnt_next = 16'd0;
                    crc_next      = CRC_INIT;
                    aborted_next  = 1'b0;
                end
            end

            PREAMBLE: begin
                tx_data_next = 8'h55;
                tx_ctl_next  = CTL_DATA;
                if (sub_cnt_reg == 8'd6) begin
                    state_next   = SFD;
                    sub_cnt_next = 8'd0;
                end else begin
                    sub_cnt_next = sub_cnt_reg + 8'd1;
                end
            end

            SFD: begin
                tx_data_next = 8'hD5;
                tx_ctl_next  = CTL_DATA;
                state_next   = PAYLOAD;
            end

            PAYLOAD: begin
                if (s_valid) begin
                    tx_data_next  = s_data;
                    tx_ctl_next   = CTL_DATA;
                    crc_next      = crc_upd;
                    byte_cnt_next = byte_cnt_inc;
                    if (s_last) begin
                        sub_cnt_next = 8'd0;
                        state_next   = (byte_cnt_plus1 < MIN_FRAME_L) ? PAD : FCS;
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame with one
                    // error byte and swallow the rest of it.
                    tx_data_next = 8'h00;
                    tx_ctl_next  = CTL_ERR;
                    aborted_next = 1'b1;
                    state_next   = DISCARD;
                end
            end

            PAD: begin
                tx_data_next  = 8'h00;
                tx_ctl_next   = CTL_DATA;
                crc_next      = crc_upd;
                byte_cnt_next = byte_cnt_inc;
                if (byte_cnt_plus1 >= MIN_FRAME_L) begin
                    sub_cnt_next = 8'd0;
                    state_next   = FCS;
                end
            end

            FCS: begin
                // Send the complemented CRC LSB first, shifting it down.
                tx_data_next = ~crc_reg[7:0];
                tx_ctl_next  = CTL_DATA;
                crc_next     = {8'hFF, crc_reg[31:8]};
                if (sub_cnt_reg == 8'd3) begin
                    sub_cnt_next = 8'd0;
                    state_next   = GAP;
                end else begin
                    sub_cnt_next = sub_cnt_reg + 8'd1;
                end
            end

            DISCARD: begin
                if (s_valid && s_last) begin
                    sub_cnt_next = 8'd0;
                    state_next   = GAP;
                end
            end

            GAP: begin
                if (sub_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    if (aborted_reg) begin
                        underruns_next = underruns_reg + 16'd1;
                    end else begin
                        frames_sent_next = frames_sent_reg + 16'd1;
                    end
                end else begin
                    sub_cnt_next = sub_cnt_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Testbench for rgmii_tx_framer.
// The stimulus process pushes every expected non-idle {tx_ctl,tx_data}
// into a queue before driving a frame; monitor processes pop and compare
// whenever the DUT emits a non-idle byte, and check inter-frame gaps.
// A second instance with MIN_FRAME=0 carries the "123456789" check vector.
`timescale 1ns/1ps
module tb_rgmii_tx_framer;

    localparam int MINF = 60;
    localparam int GAPN = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        en0 = 1'b0;
    logic        s_valid0;

    logic        s_ready, busy;
    logic [7:0]  tx_data;
    logic [1:0]  tx_ctl;
    logic [15:0] frames_sent, underruns;

    logic        s_ready0, busy0;
    logic [7:0]  tx_data0;
    logic [1:0]  tx_ctl0;
    logic [15:0] frames_sent0, underruns0;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp0_q[$];
    bit         gap_q[$];      // 1: gap must be exactly GAPN, 0: at least GAPN
    logic [7:0] pl[$];

    assign s_valid0 = s_valid & en0;

    always #4 clk = ~clk;

    rgmii_tx_framer #(.MIN_FRAME(MINF), .IFG(GAPN)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .tx_data(tx_data), .tx_ctl(tx_ctl), .busy(busy),
        .frames_sent(frames_sent), .underruns(underruns)
    );

    rgmii_tx_framer #(.MIN_FRAME(0), .IFG(GAPN)) dut0 (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid0), .s_last(s_last), .s_ready(s_ready0),
        .tx_data(tx_data0), .tx_ctl(tx_ctl0), .busy(busy0),
        .frames_sent(frames_sent0), .underruns(underruns0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    // Reference CRC-32 step: reflected polynomial, one data bit at a time.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Expected bytes for the frame in pl. drop_after >= 0 models an underrun
    // after that many payload bytes; keep >= 0 truncates the expectation.
    task automatic push_frame(input int drop_after, input int keep, input bit exact_gap);
        logic [9:0]  f[$];
        logic [31:0] c;
        logic [31:0] fcs;
        int n;
        for (int i = 0; i < 7; i++) f.push_back({2'b11, 8'h55});
        f.push_back({2'b11, 8'hD5});
        c = 32'hFFFFFFFF;
        if (drop_after >= 0) begin
            for (int i = 0; i < drop_after; i++) f.push_back({2'b11, pl[i]});
            f.push_back({2'b01, 8'h00});
        end else begin
            n = 0;
            for (int i = 0; i < pl.size(); i++) begin
                f.push_back({2'b11, pl[i]});
                c = crc_step(c, pl[i]);
                n++;
            end
            while (n < MINF) begin
                f.push_back({2'b11, 8'h00});
                c = crc_step(c, 8'h00);
                n++;
            end
            fcs = ~c;
            for (int b = 0; b < 4; b++) f.push_back({2'b11, fcs[8*b +: 8]});
        end
        if (keep >= 0) while (f.size() > keep) void'(f.pop_back());
        foreach (f[i]) exp_q.push_back(f[i]);
        gap_q.push_back(exact_gap);
    endtask

    // Drive the frame in pl; handshakes are decided at the negedge from the
    // state-only s_ready. s_valid is left high after the last byte.
    task automatic send_frame(input int idle_before, input int drop_after);
        int  idx;
        int  cyc;
        bit  dropped;
        for (int i = 0; i < idle_before; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        idx = 0;
        cyc = 0;
        dropped = 1'b0;
        while (idx < pl.size()) begin
            @(negedge clk);
            cyc++;
            if (cyc > 2 * pl.size() + 100) begin
                bound_fail("send_frame");
                break;
            end
            if (drop_after >= 0 && idx == drop_after && !dropped && s_ready) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                dropped = 1'b1;
            end else begin
                s_valid = 1'b1;
                s_data  = pl[idx];
                s_last  = (idx == pl.size() - 1);
                if (s_ready) idx++;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || exp0_q.size() != 0 || busy || busy0) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 5000) bound_fail(name);
    endtask

    // Monitor for the default-parameter instance.
    initial begin : mon_main
        int  idle_run;
        bit  prev_active;
        bit  have_prev;
        bit  g;
        logic [9:0] e;
        idle_run = 0;
        prev_active = 1'b0;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_prev = 1'b0;
                prev_active = 1'b0;
                idle_run = 0;
            end
            if (tx_ctl == 2'b00) begin
                check("idle_data", {24'h0, tx_data}, 32'h0);
                idle_run++;
                prev_active = 1'b0;
            end else begin
                if (!prev_active) begin
                    if (gap_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_start: unexpected frame start, got ctl=%b data=0x%02h", tx_ctl, tx_data);
                    end else begin
                        g = gap_q.pop_front();
                        if (have_prev) begin
                            if (g) check("ifg_exact", idle_run, GAPN);
                            else begin
                                checks++;
                                if (idle_run < GAPN) begin
                                    errors++;
                                    $display("FAIL ifg_min: got %0d idle cycles, required >= %0d", idle_run, GAPN);
                                end
                            end
                        end
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_byte: got ctl=%b data=0x%02h, expected nothing", tx_ctl, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {22'h0, tx_ctl, tx_data}, {22'h0, e});
                end
                prev_active = 1'b1;
                have_prev = 1'b1;
                idle_run = 0;
            end
        end
    end

    // Monitor for the MIN_FRAME=0 instance.
    initial begin : mon_zero
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (tx_ctl0 != 2'b00) begin
                if (exp0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL kat_byte: got ctl=%b data=0x%02h, expected nothing", tx_ctl0, tx_data0);
                end else begin
                    e = exp0_q.pop_front();
                    check("kat_byte", {22'h0, tx_ctl0, tx_data0}, {22'h0, e});
                end
            end
        end
    end

    initial begin : stim
        int c;
        int n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_ctl", {30'h0, tx_ctl}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_s_ready", {31'h0, s_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frames", {16'h0, frames_sent}, 32'h0);
        check("rst_underruns", {16'h0, underruns}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // "123456789" on both instances; MIN_FRAME=0 one has a fixed FCS.
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 7; i++) exp0_q.push_back({2'b11, 8'h55});
        exp0_q.push_back({2'b11, 8'hD5});
        for (int i = 0; i < 9; i++) exp0_q.push_back({2'b11, 8'h31 + 8'(i)});
        exp0_q.push_back({2'b11, 8'h26});
        exp0_q.push_back({2'b11, 8'h39});
        exp0_q.push_back({2'b11, 8'hF4});
        exp0_q.push_back({2'b11, 8'hCB});
        push_frame(-1, -1, 1'b0);
        en0 = 1'b1;
        send_frame(0, -1);
        go_idle();
        en0 = 1'b0;
        wait_idle("kat_drain");
        check("kat_frames_sent", {16'h0, frames_sent0}, 32'd1);
        check("kat_underruns", {16'h0, underruns0}, 32'd0);
        check("frames_after_1", {16'h0, frames_sent}, 32'd1);

        // Single byte 0xAB, padded to MIN_FRAME.
        pl.delete();
        pl.push_back(8'hAB);
        push_frame(-1, -1, 1'b0);
        send_frame(3, -1);
        go_idle();
        wait_idle("short_drain");
        check("frames_after_short", {16'h0, frames_sent}, 32'd2);

        // Two back-to-back 100-byte frames with s_valid held high.
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i * 7 + 3));
        push_frame(-1, -1, 1'b0);
        push_frame(-1, -1, 1'b1);
        send_frame(1, -1);
        send_frame(0, -1);
        go_idle();
        wait_idle("b2b_drain");
        check("frames_after_b2b", {16'h0, frames_sent}, 32'd4);

        // Underrun after payload byte 20 of 100.
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(8'hC0 ^ i));
        push_frame(20, -1, 1'b0);
        send_frame(2, 20);
        go_idle();
        wait_idle("underrun_drain");
        check("underruns_after", {16'h0, underruns}, 32'd1);
        check("frames_after_underrun", {16'h0, frames_sent}, 32'd4);

        // Reset pulsed so it lands on the edge of FCS byte 2.
        pl.delete();
        for (int i = 0; i < 70; i++) pl.push_back(8'(i * 13));
        push_frame(-1, 8 + 70 + 2, 1'b0);
        send_frame(2, -1);
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (c >= 200) bound_fail("reset_wait");
        reset = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_tx_ctl", {30'h0, tx_ctl}, 32'h0);
        check("rst_mid_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_mid_frames", {16'h0, frames_sent}, 32'd0);
        check("rst_mid_underruns", {16'h0, underruns}, 32'd0);
        check("rst_mid_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'(8'hA0 + i));
        push_frame(-1, -1, 1'b0);
        send_frame(2, -1);
        go_idle();
        wait_idle("post_reset_drain");
        check("frames_post_reset", {16'h0, frames_sent}, 32'd1);
        check("underruns_post_reset", {16'h0, underruns}, 32'd0);

        // Random lengths with random idle gaps before start of frame.
        for (int f = 0; f < 4; f++) begin
            pl.delete();
            n = $urandom_range(1, 1500);
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
            push_frame(-1, -1, 1'b0);
            send_frame($urandom_range(0, 20), -1);
            $display("random frame %0d: %0d payload bytes queued", f, n);
        end
        go_idle();
        wait_idle("random_drain");
        check("frames_after_random", {16'h0, frames_sent}, 32'd5);
        check("underruns_after_random", {16'h0, underruns}, 32'd0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
